// File: rtl/kgp_risc_pkg.sv
// ----------------------------------------------------------------------------
// kgp_risc_pkg : shared size encodings, FSM states and lane helper for KGP_RISC
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package kgp_risc_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sp_ram.sv
// ----------------------------------------------------------------------------
// dmem_sp_ram : single-port synchronous data RAM, byte-lane write enables,
//               one-cycle registered read, array not reset.  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] wr_en,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  // One byte-wide array per lane keeps each lane's storage in its own process.
  for (genvar g = 0; g < DATA_W/8; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en[g]) mem[addr] <= wdata[g*8 +: 8];
      if (rd_en)    rd_q      <= mem[addr];
    end

    assign rdata[g*8 +: 8] = rd_q;
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit : KGP_RISC data-memory stage (sized loads/stores, extension,
//                   alignment/range checks). Optional MEM_ACCESS_STATS_EN adds
//                   response counters. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import kgp_risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  localparam int LANES  = lanes(DATA_W);
  localparam int LANE_W = $clog2(LANES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state, state_nxt;
  logic                accept, resp_hs, misaligned, req_err;
  logic                write_q, signed_q, err_q;
  logic [1:0]          size_q;
  logic [LANE_W-1:0]   off_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q, ram_rdata, ram_wdata, load_data;
  logic [ADDR_W-1:0]   word_idx;
  logic [LANES-1:0]    ram_wr_en;
  logic                ram_rd_en;

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sz,
                                                  input logic [LANE_W-1:0] off);
    logic [LANES-1:0] m;
    m = LANES'((32'd1 << (32'd1 << sz)) - 32'd1);
    return m << off;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sz,
                                               input logic sgn);
    int               nbits;
    logic [DATA_W-1:0] keep;
    nbits = 8 << sz;
    if (nbits >= DATA_W) return d;
    keep = {DATA_W{1'b1}} >> (DATA_W - nbits);
    // keep ^ (keep >> 1) isolates the sign bit of the selected width
    if (sgn && (|(d & (keep ^ (keep >> 1))))) return d | ~keep;
    return d & keep;
  endfunction

  assign word_idx = req_addr >> LANE_W;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = req_addr[0];
      SIZE_W:  misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign req_err = misaligned
                 || ((req_size == SIZE_D) && (DATA_W < 64))
                 || (word_idx >= ADDR_W'(DEPTH));

  assign accept  = req_valid && (state == ST_IDLE);
  assign resp_hs = (state == ST_RESP) && resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_rd_en  = 1'b0;
    ram_wr_en  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_rd_en = !write_q;
        ram_wr_en = write_q ? lane_mask(size_q, off_q) : '0;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_hs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SIZE_B;
      off_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      signed_q <= req_signed;
      err_q    <= req_err;
      size_q   <= req_size;
      off_q    <= req_addr[LANE_W-1:0];
      idx_q    <= word_idx[IDX_W-1:0];
      wdata_q  <= req_wdata;
    end
  end

  assign ram_wdata = wdata_q << {off_q, 3'b000};

  dmem_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .wr_en (ram_wr_en),
    .rd_en (ram_rd_en),
    .addr  (idx_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM read register only reloads in ACCESS, so data holds during back-pressure.
  assign load_data  = extend(ram_rdata >> {off_q, 3'b000}, size_q, signed_q);
  assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : '0;
  assign resp_err   = resp_valid && err_q;

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (resp_hs) begin
      if (err_q)        stat_errs   <= stat_errs + 32'd1;
      else if (write_q) stat_stores <= stat_stores + 32'd1;
      else              stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit : directed table, corner sequences and randomized traffic
//                      against a byte-array reference model. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;
  import kgp_risc_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0] resp_rdata;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flat byte-addressed memory, little-endian
  logic [7:0] mem_m [4*DEPTH];

  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int nb;
    logic [63:0] v;
    nb = 1 << sz;
    rd = '0;
    er = (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
    if (er) return;
    if (w) begin
      for (int i = 0; i < nb; i++) mem_m[a + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(mem_m[a + i]) << (8*i));
      if (sg && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      rd = v[31:0];
    end
  endtask

  // One full transaction; hold = cycles resp_ready stays low once response is up
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_valid_seen", resp_valid, 1);
    rd = resp_rdata;
    er = resp_err;
    repeat (hold) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_hs", req_ready, 1);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_B;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err",   resp_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Make every RAM byte known to the model
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom;
      model(1'b1, SIZE_W, 1'b0, 32'(i*4), d, mrd, mer);
      do_req(1'b1, SIZE_W, 1'b0, 32'(i*4), d, 0, rd, er, lat);
      check("init_err", er, 0);
    end

    add_vec(1, SIZE_W, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add_vec(0, SIZE_W, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add_vec(0, SIZE_B, 1, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    add_vec(0, SIZE_B, 0, 32'h10,  32'h0,        32'h000000EF, 0);
    add_vec(1, SIZE_H, 0, 32'h12,  32'h1234,     32'h0,        0);
    add_vec(0, SIZE_W, 0, 32'h10,  32'h0,        32'h1234BEEF, 0);
    add_vec(0, SIZE_W, 0, 32'h11,  32'h0,        32'h0,        1);
    add_vec(0, SIZE_W, 0, 32'h10,  32'h0,        32'h1234BEEF, 0);
    add_vec(0, SIZE_W, 0, 32'h100, 32'h0,        32'h0,        1);
    add_vec(0, SIZE_D, 0, 32'h18,  32'h0,        32'h0,        1);
    add_vec(1, SIZE_H, 0, 32'h13,  32'hFFFF,     32'h0,        1);
    add_vec(0, SIZE_H, 1, 32'h12,  32'h0,        32'h00001234, 0);
    add_vec(1, SIZE_W, 0, 32'h20,  32'h11223344, 32'h0,        0);
    add_vec(0, SIZE_H, 1, 32'h22,  32'h0,        32'h00001122, 0);
    add_vec(1, SIZE_B, 0, 32'h23,  32'hF0,       32'h0,        0);
    add_vec(0, SIZE_H, 1, 32'h22,  32'h0,        32'hFFFFF022, 0);
    add_vec(1, SIZE_B, 0, 32'h21,  32'hFFFFFF5A, 32'h0,        0);
    add_vec(0, SIZE_W, 0, 32'h20,  32'h0,        32'hF0225A44, 0);
    add_vec(0, SIZE_B, 1, 32'h20,  32'h0,        32'h00000044, 0);
    add_vec(1, SIZE_W, 0, 32'hFC,  32'hCAFEF00D, 32'h0,        0);
    add_vec(0, SIZE_H, 0, 32'hFE,  32'h0,        32'h0000CAFE, 0);
    add_vec(0, SIZE_H, 1, 32'hFE,  32'h0,        32'hFFFFCAFE, 0);

    foreach (vecs[i]) begin
      model(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, mrd, mer);
      do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, 0, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_err ? 1 : 2);
    end

    // Back-pressure: response held 5 cycles, a waiting request must stay out
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_W; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = '0; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("bp_resp_valid", resp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_rdata_stable", resp_rdata, 32'h1234BEEF);
      check("bp_err_stable",   resp_err, 0);
      check("bp_req_ready",    req_ready, 0);
      check("bp_valid_held",   resp_valid, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after_hs", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_next_accepted", req_ready, 0);
    @(posedge clk);
    #1;
    check("bp_next_valid", resp_valid, 1);
    check("bp_next_rdata", resp_rdata, 32'h1234BEEF);
    @(posedge clk);
    #1;

    // Reset during the ACCESS cycle of a store: nothing committed
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_W; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmid_req_ready",  req_ready, 1);
    check("rmid_resp_valid", resp_valid, 0);
    check("rmid_resp_rdata", resp_rdata, 0);
    check("rmid_resp_err",   resp_err, 0);
`ifdef MEM_ACCESS_STATS_EN
    check("rmid_stat_loads",  stat_loads, 0);
    check("rmid_stat_stores", stat_stores, 0);
    check("rmid_stat_errs",   stat_errs, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, mrd, mer);
    do_req(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    check("rmid_old_value", rd, 32'hF0225A44);
    check("rmid_model_agree", rd, mrd);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      int          hold;
      w    = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      a    = 32'($urandom_range(0, 4*DEPTH + 15));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      model(w, sz, sg, a, wd, mrd, mer);
      do_req(w, sz, sg, a, wd, hold, rd, er, lat);
      check("rnd_rdata",   rd, mrd);
      check("rnd_err",     er, mer);
      check("rnd_latency", lat, mer ? 1 : 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
